regfile_spi_dump: RTL and testbench
===================================

// Module: regfile_spi_dump
// PURPOSE
//  Debug read-out engine for the core register file: on a start pulse it reads
//  registers first_reg..last_reg through a spare register-file read port.
//  Each 32-bit value is shifted out MSB-first on an SPI-mode-0 master link (sclk/mosi/cs_n).
//  It drives the register-file read address and samples the combinational read data,
//  giving the off-chip SPI host a view of architectural state.
// PARAMETERS
//  CLK_DIV   2   CLK cycles per sclk half-period (>=1)
//  MAX_REG   18  highest implemented register index; larger indices are clamped
// PORTS
//  CLK        in   1   core clock, all logic on posedge
//  reset      in   1   synchronous, active-high
//  start      in   1   one-cycle request pulse, sampled only in IDLE
//  first_reg  in   5   first register index, sampled with start
//  last_reg   in   5   last register index, sampled with start
//  rd_addr    out  5   register-file read address (registered)
//  rd_data    in   32  register-file read data (combinational from rd_addr)
//  sclk       out  1   SPI clock, idle low
//  mosi       out  1   SPI data, changes only while sclk low
//  cs_n       out  1   SPI chip select, active low, held low for the whole dump
//  busy       out  1   high from the cycle after accepted start until DONE exits
//  done       out  1   one-cycle pulse at end of dump
// BEHAVIOUR
//  Reset: state=IDLE, rd_addr=0, sclk=0, mosi=0, cs_n=1, busy=0, done=0, counters=0.
//  Reset mid-dump aborts on the next edge: cs_n rises immediately, no done pulse.
//  FSM IDLE -> LOAD -> SHIFT -> NEXT -> (LOAD | DONE) -> IDLE.
//  IDLE: on start, last_eff = min(last_reg, MAX_REG).
//   - If first_reg > last_eff, go to DONE: cs_n stays 1, no bits are sent.
//   - Otherwise rd_addr <= first_reg, go to LOAD.
//   - start asserted outside IDLE is ignored.
//  LOAD (1 cycle): shreg <= rd_data for the current rd_addr, cs_n <= 0,
//   mosi <= rd_data[31], bit_cnt <= 31, div_cnt <= 0.
//  SHIFT: div_cnt counts 0..CLK_DIV-1; each wrap toggles sclk.
//   - On a rising toggle, data is already stable.
//   - On a falling toggle with bit_cnt>0: shreg <<= 1, mosi <= next bit, bit_cnt--.
//   - On a falling toggle with bit_cnt==0: go to NEXT with sclk=0.
//  NEXT (1 cycle): if rd_addr == last_eff go to DONE, else rd_addr++ and go to LOAD.
//   cs_n stays low between words, so the frame is a contiguous 32*N bits.
//  DONE (1 cycle): cs_n <= 1, mosi <= 0, done=1, then IDLE.
//  Per-word cost: 1 (LOAD) + 64*CLK_DIV + 1 (NEXT) CLK cycles.
//  rd_addr==0 returns 0 via the register-file x0 rule; the value is sent as 32 zeros.
//  Sampling point: LOAD captures rd_data at a posedge. A register-file write on the
//   preceding negedge is visible; later writes do not affect the word in flight.
//  sclk never glitches; exactly 32 rising edges per word; no sclk edges while cs_n=1.
// TESTING
//  1. Preload x1=0xDEADBEEF, x2=0x00000001; start with first=1, last=2, CLK_DIV=2
//     -> 64 sclk rises with cs_n low, mosi bits = DEADBEEF then 00000001;
//     done 1+2*(1+128+1) cycles after start.
//  2. first=0, last=0 -> 32 zero bits, then done; rd_addr=0 throughout.
//  3. first=5, last=3 -> done one cycle after IDLE exit; cs_n never low; no sclk edges.
//  4. first=17, last=25 -> only x17 and x18 are sent (64 bits); rd_addr never exceeds 18.
//  5. Assert reset after bit 10 of word 0 -> next cycle cs_n=1, sclk=0, busy=0, no done.
//     A fresh start then sends the full word.
//  6. Pulse start again while busy -> ignored.
//     Write x1=0x12345678 during SHIFT -> the current word is unchanged; a later dump shows the new value.

Source files
------------

// File: rtl/regfile_spi_dump.sv
// Debug read-out engine: walks a register-file read port over a register range
// and streams each 32-bit word MSB-first on an SPI mode-0 master link.
module regfile_spi_dump #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned MAX_REG = 18
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  first_reg,
  input  logic [4:0]  last_reg,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0] MAX_IDX = (MAX_REG > 31) ? 5'd31 : 5'(MAX_REG);

  state_t           state;
  logic [4:0]       last_eff;
  logic [4:0]       last_clamped;
  logic [30:0]      shreg;    // bit 31 of the word goes straight to mosi at LOAD
  logic [4:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;

  always_comb begin
    last_clamped = (last_reg > MAX_IDX) ? MAX_IDX : last_reg;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= S_IDLE;
      last_eff <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      rd_addr  <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            last_eff <= last_clamped;
            if (first_reg > last_clamped) begin
              state <= S_DONE;
            end else begin
              rd_addr <= first_reg;
              state   <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          shreg   <= rd_data[30:0];
          mosi    <= rd_data[31];
          cs_n    <= 1'b0;
          sclk    <= 1'b0;
          bit_cnt <= 5'd31;
          div_cnt <= '0;
          state   <= S_SHIFT;
        end

        S_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            // Falling toggle: advance the data while the slave holds off sampling
            if (sclk) begin
              if (bit_cnt != 5'd0) begin
                mosi    <= shreg[30];
                shreg   <= {shreg[29:0], 1'b0};
                bit_cnt <= bit_cnt - 5'd1;
              end else begin
                state <= S_NEXT;
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        S_NEXT: begin
          if (rd_addr == last_eff) begin
            state <= S_DONE;
          end else begin
            rd_addr <= rd_addr + 5'd1;
            state   <= S_LOAD;
          end
        end

        S_DONE: begin
          cs_n  <= 1'b1;
          mosi  <= 1'b0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_spi_dump.sv
// Bench for regfile_spi_dump: cycle-level arithmetic model of the SPI frame,
// a register-file array driving rd_data, and directed dump scenarios.
module tb_regfile_spi_dump;
  localparam int CLK_DIV = 2;
  localparam int MAX_REG = 18;
  localparam int WC      = 2 + 64 * CLK_DIV;  // cycles per word
  localparam int SHIFT_C = 64 * CLK_DIV;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  first_reg = '0;
  logic [4:0]  last_reg = '0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        sclk, mosi, cs_n, busy, done;

  logic [31:0] regs [32];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;

  assign rd_data = (rd_addr == 5'd0) ? 32'd0 : regs[rd_addr];

  regfile_spi_dump #(.CLK_DIV(CLK_DIV), .MAX_REG(MAX_REG)) dut (
    .CLK(CLK), .reset(reset), .start(start), .first_reg(first_reg),
    .last_reg(last_reg), .rd_addr(rd_addr), .rd_data(rd_data), .sclk(sclk),
    .mosi(mosi), .cs_n(cs_n), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state for the dump in flight
  bit          m_active = 1'b0;
  int          m_k0, m_n, m_done_at, m_abort_at;
  logic [4:0]  m_first = '0;
  logic [4:0]  exp_idle_rd = '0;
  logic [31:0] m_words [$];
  bit          rx_bits [$];
  logic [31:0] rx_words [$];
  int          done_seen = -1;
  int          rises = 0;
  int          max_rd = 0;
  logic        sclk_prev = 1'b0;

  bit          in_dump;
  logic        e_busy, e_done, e_csn, e_sclk, e_mosi;
  logic [4:0]  e_rd;
  logic [31:0] cw, v;
  int          t, w, j;

  task automatic launch(input logic [4:0] f, input logic [4:0] l);
    int le;
    le = (int'(l) > MAX_REG) ? MAX_REG : int'(l);
    m_first = f;
    m_words.delete();
    m_n = (int'(f) > le) ? 0 : le - int'(f) + 1;
    for (int r = int'(f); r <= le; r++) m_words.push_back((r == 0) ? 32'd0 : regs[r]);
    m_k0       = cyc + 1;
    m_done_at  = m_k0 + 1 + m_n * WC;
    m_abort_at = 32'h7fffffff;
    m_active   = 1'b1;
    rx_bits.delete();
    rises     = 0;
    done_seen = -1;
    max_rd    = 0;
  endtask

  always @(posedge CLK) begin
    #1;
    cyc++;
    if (sclk === 1'b1 && sclk_prev === 1'b0) begin
      rises++;
      if (cs_n === 1'b0) rx_bits.push_back(mosi);
    end
    sclk_prev = sclk;
    if (done === 1'b1) done_seen = cyc;
    if (int'(rd_addr) > max_rd) max_rd = int'(rd_addr);

    in_dump = m_active && (cyc < m_abort_at);
    if (m_active && cyc == m_abort_at) begin
      exp_idle_rd = '0;
      rx_bits.delete();
    end
    if (reset && !m_active) exp_idle_rd = '0;
    if (in_dump && cyc == m_done_at) begin
      chk("frame_bits", rx_bits.size(), 32 * m_n);
      rx_words.delete();
      for (int k = 0; k < m_n && (k + 1) * 32 <= rx_bits.size(); k++) begin
        v = '0;
        for (int b = 0; b < 32; b++) v = {v[30:0], rx_bits[k * 32 + b]};
        rx_words.push_back(v);
        chk("frame_word", v, m_words[k]);
      end
      if (m_n > 0) exp_idle_rd = m_first + 5'(m_n - 1);
    end

    e_busy = in_dump && cyc >= m_k0 && cyc < m_done_at;
    e_done = in_dump && cyc == m_done_at;
    e_csn  = 1'b1;
    e_sclk = 1'b0;
    e_mosi = 1'b0;
    e_rd   = exp_idle_rd;
    if (e_busy && m_n > 0) begin
      if (cyc == m_k0) begin
        e_rd = m_first;
      end else begin
        t  = cyc - m_k0 - 1;
        w  = t / WC;
        j  = t % WC;
        cw = m_words[w];
        e_csn  = 1'b0;
        e_rd   = m_first + 5'(w) + ((j == WC - 1 && w < m_n - 1) ? 5'd1 : 5'd0);
        e_sclk = (j >= 1 && j <= SHIFT_C) ? 1'((j / CLK_DIV) % 2) : 1'b0;
        e_mosi = (j < SHIFT_C) ? cw[31 - j / (2 * CLK_DIV)] : cw[0];
      end
    end
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("cs_n", cs_n, e_csn);
    chk("sclk", sclk, e_sclk);
    chk("mosi", mosi, e_mosi);
    chk("rd_addr", rd_addr, e_rd);
  end

  task automatic begin_dump(input logic [4:0] f, input logic [4:0] l);
    @(negedge CLK);
    first_reg = f;
    last_reg  = l;
    start     = 1'b1;
    launch(f, l);
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic finish_dump();
    repeat (m_n * WC + 4) @(negedge CLK);
  endtask

  function automatic logic [31:0] word_at(input int i);
    return (rx_words.size() > i) ? rx_words[i] : 32'hxxxxxxxx;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h5A000000 | i;
    regs[0]  = 32'hFFFFFFFF;
    regs[1]  = 32'hDEADBEEF;
    regs[2]  = 32'h00000001;
    regs[17] = 32'hC0FFEE17;
    regs[18] = 32'h80000001;
    regs[19] = 32'h13131313;

    repeat (3) @(negedge CLK);
    reset = 1'b0;
    repeat (2) @(negedge CLK);

    // Two words, back to back
    begin_dump(5'd1, 5'd2);
    finish_dump();
    chk("t1_latency", done_seen - m_k0, 261);
    chk("t1_rises", rises, 64);
    chk("t1_w0", word_at(0), 32'hDEADBEEF);
    chk("t1_w1", word_at(1), 32'h00000001);

    // x0 reads as zero
    begin_dump(5'd0, 5'd0);
    finish_dump();
    chk("t2_latency", done_seen - m_k0, 131);
    chk("t2_rises", rises, 32);
    chk("t2_w0", word_at(0), 32'h00000000);
    chk("t2_max_rd", max_rd, 0);

    // Empty range
    begin_dump(5'd5, 5'd3);
    finish_dump();
    chk("t3_latency", done_seen - m_k0, 1);
    chk("t3_rises", rises, 0);

    // Range clamped at MAX_REG
    begin_dump(5'd17, 5'd25);
    finish_dump();
    chk("t4_rises", rises, 64);
    chk("t4_max_rd", max_rd, 18);
    chk("t4_w0", word_at(0), 32'hC0FFEE17);
    chk("t4_w1", word_at(1), 32'h80000001);

    // Reset after bit 10 of the first word
    begin_dump(5'd1, 5'd1);
    repeat (1 + 10 * 2 * CLK_DIV + 2) @(negedge CLK);
    chk("t5_rises_before_reset", rises, 11);
    reset = 1'b1;
    m_abort_at = cyc + 1;
    @(negedge CLK);
    reset = 1'b0;
    repeat (4) @(negedge CLK);
    chk("t5_no_done", done_seen, -1);
    begin_dump(5'd1, 5'd1);
    finish_dump();
    chk("t5_rises", rises, 32);
    chk("t5_w0", word_at(0), 32'hDEADBEEF);

    // Start while busy is ignored; write during SHIFT does not alter the word in flight
    begin_dump(5'd1, 5'd2);
    repeat (20) @(negedge CLK);
    first_reg = 5'd3;
    last_reg  = 5'd3;
    start     = 1'b1;
    @(negedge CLK);
    start   = 1'b0;
    regs[1] = 32'h12345678;
    finish_dump();
    chk("t6_latency", done_seen - m_k0, 261);
    chk("t6_w0", word_at(0), 32'hDEADBEEF);
    chk("t6_w1", word_at(1), 32'h00000001);
    begin_dump(5'd1, 5'd1);
    finish_dump();
    chk("t6_new_w0", word_at(0), 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
